// File: rtl/unified_mem_arbiter.sv
// Arbiter and sequencer for a single-ported memory shared by instruction
// fetch (IF) and data memory (DM). DM has priority. One fixed-latency access
// runs at a time. The fetched instruction is held in a one-entry buffer, and
// the block produces the structural-stall controls for the pipeline.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [DATA_W-1:0] if_rdata,
    output logic              ibuf_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall,
    output logic              PCWrite,
    output logic              IF_ID_Write
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LATENCY);

    typedef enum logic { S_IDLE, S_ACCESS } state_t;
    typedef enum logic { OWN_IF, OWN_DM } owner_t;

    state_t             r_state;
    owner_t             r_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_discard;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_ibuf;
    logic               r_ibuf_valid;

    state_t             w_state_nxt;
    logic               w_dm_req;
    logic               w_grant_dm;
    logic               w_grant_if;
    logic               w_complete;
    logic               w_if_capture;
    logic               w_dm_done;
    logic               w_pipe_stall;
    logic               w_pc_write;

    // Arbitration and access sequencing: DM wins, fetch only into an empty buffer.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_dm  = 1'b0;
        w_grant_if  = 1'b0;
        w_complete  = 1'b0;
        w_dm_req    = dm_read | dm_write;
        case (r_state)
            S_IDLE: begin
                if (w_dm_req) begin
                    w_grant_dm  = 1'b1;
                    w_state_nxt = S_ACCESS;
                end else if (if_req && !r_ibuf_valid && !flush) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == CNT_LAST) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode; reset forces the memory strobes and handshakes inactive
    // even though the registers only clear at the end of the reset cycle.
    always_comb begin
        w_dm_done    = !rst && w_complete && (r_owner == OWN_DM);
        w_pipe_stall = w_dm_req && !w_dm_done;
        w_pc_write   = !rst && r_ibuf_valid && !w_pipe_stall && !flush;
        w_if_capture = w_complete && (r_owner == OWN_IF) && !r_discard && !flush;
        mem_en       = !rst && (r_state == S_ACCESS) && (r_cnt == CNT_FIRST);
        mem_we       = mem_en && r_we;
        mem_addr     = rst ? '0 : r_addr;
        mem_wdata    = rst ? '0 : r_wdata;
        dm_done      = w_dm_done;
        dm_rdata     = mem_rdata;
        if_rdata     = r_ibuf;
        ibuf_valid   = r_ibuf_valid;
        pipe_stall   = w_pipe_stall;
        PCWrite      = w_pc_write;
        IF_ID_Write  = w_pc_write;
    end

    // Control state: FSM, latency counter, owner, write flag and discard flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_owner   <= OWN_IF;
            r_we      <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_dm || w_grant_if) begin
                r_cnt   <= CNT_FIRST;
                r_owner <= w_grant_dm ? OWN_DM : OWN_IF;
                r_we    <= w_grant_dm && dm_write;
            end else if (w_complete) begin
                r_cnt <= '0;
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + CNT_FIRST;
            end
            // A flushed fetch still runs to completion; its data is dropped.
            if (w_complete) begin
                r_discard <= 1'b0;
            end else if (flush && (r_state == S_ACCESS) && (r_owner == OWN_IF)) begin
                r_discard <= 1'b1;
            end
        end
    end

    // Address and store data are captured at grant and held for the access.
    always_ff @(posedge clk) begin
        if (w_grant_dm) begin
            r_addr  <= dm_addr;
            r_wdata <= dm_wdata;
        end else if (w_grant_if) begin
            r_addr  <= if_addr;
        end
    end

    // Instruction buffer: filled by a completed fetch, drained by PCWrite,
    // invalidated by flush (flush takes precedence over PCWrite).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ibuf       <= '0;
            r_ibuf_valid <= 1'b0;
        end else begin
            if (flush) begin
                r_ibuf_valid <= 1'b0;
            end else if (w_pc_write) begin
                r_ibuf_valid <= 1'b0;
            end else if (w_if_capture) begin
                r_ibuf_valid <= 1'b1;
            end
            if (w_if_capture) begin
                r_ibuf <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter with LATENCY=2: a per-cycle
// vector table plus hand-written back-to-back DM sequences.
module tb_unified_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          flush;
    logic          dm_read;
    logic          dm_write;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_done;
    logic [DW-1:0] dm_rdata;
    logic [DW-1:0] if_rdata;
    logic          ibuf_valid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          pipe_stall;
    logic          PCWrite;
    logic          IF_ID_Write;

    int n_chk  = 0;
    int n_fail = 0;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .flush(flush),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .if_rdata(if_rdata), .ibuf_valid(ibuf_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pipe_stall(pipe_stall), .PCWrite(PCWrite),
        .IF_ID_Write(IF_ID_Write)
    );

    always #5 clk = ~clk;

    // Memory contents as seen by the bench.
    function automatic logic [63:0] mm(input logic [63:0] a);
        if (a == 64'h40) return 64'h0000_0000_0050_0093;
        return {a[31:0] ^ 32'hCAFE_0000, ~a[31:0]};
    endfunction

    // Two-cycle memory: address taken on the mem_en cycle, data valid next cycle.
    logic [AW-1:0] r_pend = '0;
    always @(posedge clk) if (mem_en) r_pend <= mem_addr;
    assign mem_rdata = mm(r_pend);

    typedef struct {
        logic          rst, ifr;
        logic [63:0]   ia;
        logic          fl, dr, dw;
        logic [63:0]   da, wd;
        logic          en, we;
        logic [63:0]   ea;
        logic          ca, cw, done, stall, iv;
        logic [63:0]   idata;
        logic          pcw;
    } vec_t;

    function automatic vec_t V(
        input logic r, input logic ifr, input logic [63:0] ia, input logic fl,
        input logic dr, input logic dw, input logic [63:0] da, input logic [63:0] wd,
        input logic en, input logic we, input logic [63:0] ea, input logic ca, input logic cw,
        input logic done, input logic stall, input logic iv, input logic [63:0] idata,
        input logic pcw);
        vec_t v;
        v.rst = r; v.ifr = ifr; v.ia = ia; v.fl = fl; v.dr = dr; v.dw = dw;
        v.da = da; v.wd = wd; v.en = en; v.we = we; v.ea = ea; v.ca = ca; v.cw = cw;
        v.done = done; v.stall = stall; v.iv = iv; v.idata = idata; v.pcw = pcw;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; if_req = v.ifr; if_addr = v.ia; flush = v.fl;
        dm_read = v.dr; dm_write = v.dw; dm_addr = v.da; dm_wdata = v.wd;
    endtask

    vec_t tbl[$];
    vec_t sb[$];

    initial begin
        vec_t e;
        int   cyc;
        int   en_cnt;
        logic [63:0] m80, m88;
        m80 = mm(64'h80);
        m88 = mm(64'h88);

        // reset
        tbl.push_back(V(1,0,0,0,1,0,0,0,        0,0,0,1,1,       0,1,0,0,0));
        tbl.push_back(V(1,0,0,0,0,0,0,0,        0,0,0,1,1,       0,0,0,0,0));
        // fetch of 0x40
        tbl.push_back(V(0,1,'h40,0,0,0,0,0,     0,0,0,0,0,       0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        1,0,'h40,1,0,    0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        0,0,'h40,1,0,    0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        0,0,0,0,0,       0,0,1,'h00500093,1));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        0,0,0,0,0,       0,0,0,0,0));
        // contention: DM read and fetch together
        tbl.push_back(V(0,1,'h80,0,1,0,'h100,0, 0,0,0,0,0,       0,1,0,0,0));
        tbl.push_back(V(0,1,'h80,0,1,0,'h100,0, 1,0,'h100,1,0,   0,1,0,0,0));
        tbl.push_back(V(0,1,'h80,0,1,0,'h100,0, 0,0,'h100,1,0,   1,0,0,0,0));
        tbl.push_back(V(0,1,'h80,0,0,0,0,0,     0,0,0,0,0,       0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        1,0,'h80,1,0,    0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        0,0,'h80,1,0,    0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        0,0,0,0,0,       0,0,1,m80,1));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        0,0,0,0,0,       0,0,0,0,0));
        // store
        tbl.push_back(V(0,0,0,0,0,1,'h200,'hDEADBEEF, 0,0,0,0,0,      0,1,0,0,0));
        tbl.push_back(V(0,0,0,0,0,1,'h200,'hDEADBEEF, 1,1,'h200,1,1,  0,1,0,0,0));
        tbl.push_back(V(0,0,0,0,0,1,'h200,'hDEADBEEF, 0,0,'h200,1,1,  1,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        0,0,0,0,0,       0,0,0,0,0));
        // flush mid-fetch, then refetch at 0x80
        tbl.push_back(V(0,1,'h40,0,0,0,0,0,     0,0,0,0,0,       0,0,0,0,0));
        tbl.push_back(V(0,1,'h80,1,0,0,0,0,     1,0,'h40,1,0,    0,0,0,0,0));
        tbl.push_back(V(0,1,'h80,0,0,0,0,0,     0,0,'h40,1,0,    0,0,0,0,0));
        tbl.push_back(V(0,1,'h80,0,0,0,0,0,     0,0,0,0,0,       0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        1,0,'h80,1,0,    0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        0,0,0,0,0,       0,0,0,0,0));
        // buffer hold while a DM read is pending
        tbl.push_back(V(0,1,'h88,0,1,0,'h300,0, 0,0,0,0,0,       0,1,1,m80,0));
        tbl.push_back(V(0,1,'h88,0,1,0,'h300,0, 1,0,'h300,1,0,   0,1,1,m80,0));
        tbl.push_back(V(0,1,'h88,0,1,0,'h300,0, 0,0,'h300,1,0,   1,0,1,m80,1));
        tbl.push_back(V(0,1,'h88,0,0,0,0,0,     0,0,0,0,0,       0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        1,0,'h88,1,0,    0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        0,0,0,0,0,       0,0,0,0,0));
        // flush coinciding with a full buffer: flush wins
        tbl.push_back(V(0,0,0,1,0,0,0,0,        0,0,0,0,0,       0,0,1,m88,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        0,0,0,0,0,       0,0,0,0,0));
        // reset in the middle of a fetch
        tbl.push_back(V(0,1,'h40,0,0,0,0,0,     0,0,0,0,0,       0,0,0,0,0));
        tbl.push_back(V(1,0,0,0,0,0,0,0,        0,0,0,1,1,       0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        0,0,0,0,0,       0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        0,0,0,0,0,       0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,        0,0,0,0,0,       0,0,0,0,0));

        // settle reset before the table starts
        drive(V(1,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            #2;
            e = sb.pop_front();
            chk("mem_en",     i, 64'(mem_en),     64'(e.en));
            chk("mem_we",     i, 64'(mem_we),     64'(e.we));
            chk("dm_done",    i, 64'(dm_done),    64'(e.done));
            chk("pipe_stall", i, 64'(pipe_stall), 64'(e.stall));
            chk("ibuf_valid", i, 64'(ibuf_valid), 64'(e.iv));
            chk("PCWrite",    i, 64'(PCWrite),    64'(e.pcw));
            chk("IF_ID_Write",i, 64'(IF_ID_Write),64'(e.pcw));
            if (e.ca) chk("mem_addr", i, mem_addr, e.ea);
            if (e.cw) chk("mem_wdata", i, mem_wdata, e.rst ? 64'h0 : e.wd);
            if (e.iv) chk("if_rdata", i, if_rdata, e.idata);
            if (e.done && e.dr && !e.dw) chk("dm_rdata", i, dm_rdata, mm(e.da));
        end

        // back-to-back DM read then DM write (both request lines high)
        @(negedge clk);
        drive(V(0,0,0,0,1,0,'h400,0, 0,0,0,0,0, 0,0,0,0,0));
        cyc = 0;
        #2;
        while (!dm_done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            #2;
        end
        chk("rd_latency", 100, 64'(cyc), 64'd2);
        chk("rd_data", 100, dm_rdata, mm(64'h400));

        @(negedge clk);
        drive(V(0,0,0,0,1,1,'h408,'h1234_5678, 0,0,0,0,0, 0,0,0,0,0));
        cyc = 0;
        en_cnt = 0;
        #2;
        while (!dm_done && cyc < 10) begin
            if (mem_en) begin
                en_cnt++;
                chk("wr_we", 101, 64'(mem_we), 64'd1);
                chk("wr_addr", 101, mem_addr, 64'h408);
                chk("wr_wdata", 101, mem_wdata, 64'h1234_5678);
            end
            @(negedge clk);
            cyc++;
            #2;
        end
        chk("wr_latency", 101, 64'(cyc), 64'd2);
        chk("wr_en_pulses", 101, 64'(en_cnt), 64'd1);

        @(negedge clk);
        drive(V(0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));
        #2;
        chk("idle_stall", 102, 64'(pipe_stall), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
